// File: rtl/core_output_arbiter.sv
// Round-robin arbiter feeding the correction output queue from NUM_CORES cores.
// Locks onto one core for a whole candidate group so groups never interleave.
module core_output_arbiter #(
  parameter int unsigned MAX_READ_BIT_WIDTH       = 8,
  parameter int unsigned MAX_READ_WIDTH           = 1 << MAX_READ_BIT_WIDTH,
  parameter int unsigned NUM_CANDIDATES_BIT_WIDTH = 5,
  parameter int unsigned NUM_BITS_NUM_CORES       = 2,
  parameter int unsigned NUM_CORES                = 1 << NUM_BITS_NUM_CORES
) (
  input  logic                                           clk,
  input  logic                                           rstb,
  input  logic [NUM_CORES*2*MAX_READ_WIDTH-1:0]          coreCandidate,
  input  logic [NUM_CORES*2*MAX_READ_WIDTH-1:0]          coreRead,
  input  logic [NUM_CORES-1:0]                           coreCandidateValid,
  input  logic [NUM_CORES*(NUM_CANDIDATES_BIT_WIDTH+1)-1:0] coreCandidateNum,
  input  logic [NUM_CORES-1:0]                           coreCandidateNumValid,
  output logic [NUM_CORES-1:0]                           coreAccept,
  input  logic                                           queueReady,
  output logic [2*MAX_READ_WIDTH-1:0]                    candidateToQueue,
  output logic [2*MAX_READ_WIDTH-1:0]                    readToQueue,
  output logic                                           candidateValidToQueue,
  output logic [NUM_CANDIDATES_BIT_WIDTH:0]              candidateNumToQueue,
  output logic                                           candidateNumValidToQueue,
  output logic [NUM_BITS_NUM_CORES-1:0]                  grantedCore,
  output logic                                           busy,
  output logic                                           abortPulse,
  output logic [15:0]                                    groupsCompleted
);

  localparam int unsigned SeqW = 2 * MAX_READ_WIDTH;
  localparam int unsigned NumW = NUM_CANDIDATES_BIT_WIDTH + 1;

  typedef enum logic [0:0] {StIdle, StGranted} state_e;

  state_e                        state_q;
  logic [NUM_BITS_NUM_CORES-1:0] grant_q;
  logic [NUM_BITS_NUM_CORES-1:0] last_grant_q;
  logic [NumW-1:0]               group_num_q;
  logic [NumW-1:0]               group_cnt_q;
  logic [15:0]                   groups_done_q;

  logic [NUM_CORES-1:0]          request;
  logic [NUM_BITS_NUM_CORES-1:0] pick;
  logic [NUM_BITS_NUM_CORES-1:0] probe;
  logic                          found;
  logic                          granted;
  logic                          transfer;
  logic                          last_xfer;

  always_comb begin
    request = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      request[i] = coreCandidateValid[i] & coreCandidateNumValid[i] &
                   (coreCandidateNum[i*NumW +: NumW] != '0);
    end
  end

  // Rotating search from last_grant+1; core count is a power of two so the add wraps.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    probe = '0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      probe = last_grant_q + NUM_BITS_NUM_CORES'(k);
      if (!found && request[probe]) begin
        found = 1'b1;
        pick  = probe;
      end
    end
  end

  always_comb begin
    granted                  = (state_q == StGranted);
    candidateValidToQueue    = granted & coreCandidateValid[grant_q] &
                               coreCandidateNumValid[grant_q];
    candidateNumValidToQueue = candidateValidToQueue;
    transfer                 = candidateValidToQueue & queueReady;
    last_xfer                = transfer && (group_cnt_q == group_num_q - NumW'(1));
    abortPulse               = granted & ~coreCandidateNumValid[grant_q];
    coreAccept               = transfer ? (NUM_CORES'(1) << grant_q) : '0;
    candidateToQueue         = coreCandidate[grant_q*SeqW +: SeqW];
    readToQueue              = coreRead[grant_q*SeqW +: SeqW];
    candidateNumToQueue      = group_num_q;
    grantedCore              = grant_q;
    busy                     = granted;
    groupsCompleted          = groups_done_q;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      last_grant_q  <= NUM_BITS_NUM_CORES'(NUM_CORES - 1);
      group_num_q   <= '0;
      group_cnt_q   <= '0;
      groups_done_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (found) begin
            grant_q     <= pick;
            group_num_q <= coreCandidateNum[pick*NumW +: NumW];
            group_cnt_q <= '0;
            state_q     <= StGranted;
          end
        end
        StGranted: begin
          if (abortPulse) begin
            group_cnt_q  <= '0;
            last_grant_q <= grant_q;
            state_q      <= StIdle;
          end else if (transfer) begin
            group_cnt_q <= group_cnt_q + NumW'(1);
            if (last_xfer) begin
              groups_done_q <= groups_done_q + 16'd1;
              last_grant_q  <= grant_q;
              state_q       <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
